// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready transfer bundle for the pipelined barrel shifter.
// The master side drives operands and accepts results; the slave side is the shifter.
interface pipelined_barrel_shifter_if #(
   parameter int DATA_SIZE = 8
);
   localparam int LOG2 = $clog2(DATA_SIZE);

   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_SIZE-1:0] data_in;
   logic [LOG2-1:0]      select;
   logic [2:0]           mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_SIZE-1:0] data_out;

   modport master (
      output in_valid, data_in, select, mode, out_ready,
      input  in_ready, out_valid, data_out
   );

   modport slave (
      input  in_valid, data_in, select, mode, out_ready,
      output in_ready, out_valid, data_out
   );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Run-time mode barrel shifter (SLL/SRL/SRA/ROL/ROR/pass) with its shift levels
// spread over PIPE_STAGES valid/ready register stages.
module pipelined_barrel_shifter #(
   parameter int DATA_SIZE   = 8,
   parameter int PIPE_STAGES = 3
) (
   input logic                     clk,
   input logic                     rst,
   pipelined_barrel_shifter_if.slave bus
);
   localparam int LOG2 = $clog2(DATA_SIZE);
   localparam int BASE = LOG2 / PIPE_STAGES;
   localparam int REM  = LOG2 % PIPE_STAGES;

   localparam logic [2:0] MODE_SLL = 3'b000;
   localparam logic [2:0] MODE_SRL = 3'b001;
   localparam logic [2:0] MODE_SRA = 3'b010;
   localparam logic [2:0] MODE_ROL = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;

   logic [PIPE_STAGES-1:0] valid_q;
   logic [PIPE_STAGES-1:0] advance;
   logic [PIPE_STAGES-1:0] load;
   logic [DATA_SIZE-1:0]   data_q   [PIPE_STAGES];
   logic [DATA_SIZE-1:0]   data_nxt [PIPE_STAGES];
   logic [LOG2-1:0]        sel_q    [PIPE_STAGES];
   logic [2:0]             mode_q   [PIPE_STAGES];

   // Stages are filled low-to-high; the first REM stages carry one extra level.
   function automatic int first_level(input int s);
      return s * BASE + ((s < REM) ? s : REM);
   endfunction

   function automatic int num_levels(input int s);
      return BASE + ((s < REM) ? 1 : 0);
   endfunction

   function automatic logic [DATA_SIZE-1:0] shift_level(
      input logic [DATA_SIZE-1:0] x,
      input logic [2:0]           m,
      input int                   amt
   );
      case (m)
         MODE_SLL: return x << amt;
         MODE_SRL: return x >> amt;
         MODE_SRA: return DATA_SIZE'($signed(x) >>> amt);
         MODE_ROL: return (x << amt) | (x >> (DATA_SIZE - amt));
         MODE_ROR: return (x >> amt) | (x << (DATA_SIZE - amt));
         default:  return x;
      endcase
   endfunction

   function automatic logic [DATA_SIZE-1:0] apply_stage(
      input logic [DATA_SIZE-1:0] x,
      input logic [LOG2-1:0]      sel,
      input logic [2:0]           m,
      input int                   s
   );
      logic [DATA_SIZE-1:0] r;
      r = x;
      for (int k = 0; k < LOG2; k++) begin
         if (k >= first_level(s) && k < first_level(s) + num_levels(s) && sel[k])
            r = shift_level(r, m, 1 << k);
      end
      return r;
   endfunction

   // room: some later stage is empty, or the output is being taken this cycle.
   always_comb begin
      logic room;
      room    = bus.out_ready;
      advance = '0;
      load    = '0;
      for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
         advance[s] = valid_q[s] && room;
         room       = room || !valid_q[s];
         load[s]    = room;
      end
   end

   always_comb begin
      data_nxt[0] = apply_stage(bus.data_in, bus.select, bus.mode, 0);
      for (int s = 1; s < PIPE_STAGES; s++)
         data_nxt[s] = apply_stage(data_q[s-1], sel_q[s-1], mode_q[s-1], s);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) begin
            data_q[s] <= '0;
            sel_q[s]  <= '0;
            mode_q[s] <= '0;
         end
      end else begin
         if (load[0]) begin
            valid_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
               data_q[0] <= data_nxt[0];
               sel_q[0]  <= bus.select;
               mode_q[0] <= bus.mode;
            end
         end
         for (int s = 1; s < PIPE_STAGES; s++) begin
            if (load[s]) begin
               valid_q[s] <= advance[s-1];
               if (advance[s-1]) begin
                  data_q[s] <= data_nxt[s];
                  sel_q[s]  <= sel_q[s-1];
                  mode_q[s] <= mode_q[s-1];
               end
            end
         end
      end
   end

   assign bus.in_ready  = load[0];
   assign bus.out_valid = valid_q[PIPE_STAGES-1];
   assign bus.data_out  = data_q[PIPE_STAGES-1];
endmodule
